// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, one-entry skid buffer, branch redirect.
// Build option IFU_BRANCH_COUNT_EN adds a saturating redirect counter (branch_count).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jmpEnable,
    input  logic [23:0] immadiateInst,
    input  logic        regjmpEnable,
    input  logic [31:0] jmpTarget,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
`ifdef IFU_BRANCH_COUNT_EN
    output logic [15:0] branch_count,
`endif
    output logic [1:0]  dbg_state
);

    // Handshakes: imem_req/imem_addr are held unchanged until the cycle imem_ack=1 completes
    // the read; the decoder takes the output word in any cycle with instr_valid=1 and stall=0.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_redir_pc;
    logic        r_discard;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_valid;
    logic [31:0] r_skid_data;
    logic [31:0] r_skid_pc;

    logic        w_consumed;
    logic        w_redirect;
    logic [31:0] w_imm_off;
    logic [31:0] w_target;

    assign w_consumed = r_valid && !stall;
    assign w_redirect = w_consumed && (regjmpEnable || jmpEnable);
    assign w_imm_off  = {{6{immadiateInst[23]}}, immadiateInst, 2'b00};
    assign w_target   = regjmpEnable ? (jmpTarget & 32'hFFFF_FFFC)
                                     : (r_instr_pc + 32'd8 + w_imm_off);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: begin
                if (!w_redirect && imem_ack && !r_discard && r_valid && stall) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == S_FETCH);
        imem_addr   = r_pc;
        instruction = r_instr;
        instr_valid = r_valid;
        instr_pc    = r_instr_pc;
        dbg_state   = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_VECTOR;
            r_redir_pc  <= RESET_VECTOR;
            r_discard   <= 1'b0;
            r_instr     <= 32'h0;
            r_instr_pc  <= 32'h0;
            r_valid     <= 1'b0;
            r_skid_data <= 32'h0;
            r_skid_pc   <= 32'h0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redirect) begin
                        r_valid <= 1'b0;
                        if (imem_ack) begin
                            r_pc <= w_target;
                        end else begin
                            // Read still in flight: let it finish at the old address, drop its data.
                            r_discard  <= 1'b1;
                            r_redir_pc <= w_target;
                        end
                    end else if (imem_ack) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_pc      <= r_redir_pc;
                        end else begin
                            r_pc <= r_pc + 32'd4;
                            if (!r_valid || w_consumed) begin
                                r_instr    <= imem_rdata;
                                r_instr_pc <= r_pc;
                                r_valid    <= 1'b1;
                            end else begin
                                r_skid_data <= imem_rdata;
                                r_skid_pc   <= r_pc;
                            end
                        end
                    end else if (w_consumed) begin
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_target;
                    end else if (!stall) begin
                        r_instr    <= r_skid_data;
                        r_instr_pc <= r_skid_pc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFU_BRANCH_COUNT_EN
    logic [15:0] r_branch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count <= 16'h0;
        end else if (w_redirect && (r_branch_count != 16'hFFFF)) begin
            r_branch_count <= r_branch_count + 16'd1;
        end
    end

    assign branch_count = r_branch_count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios, then randomized memory/decoder traffic
// checked against a program-order model of which instruction the decoder should see next.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jmpEnable;
    logic [23:0] immadiateInst;
    logic        regjmpEnable;
    logic [31:0] jmpTarget;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [1:0]  dbg_state;
`ifdef IFU_BRANCH_COUNT_EN
    logic [15:0] branch_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_VECTOR(32'h00000000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .jmpEnable     (jmpEnable),
        .immadiateInst (immadiateInst),
        .regjmpEnable  (regjmpEnable),
        .jmpTarget     (jmpTarget),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
`ifdef IFU_BRANCH_COUNT_EN
        .branch_count  (branch_count),
`endif
        .dbg_state     (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_pending;
        int          wait_cnt;
        int          n_consumed;
        int          off;
        int          exp_bc;

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        jmpEnable = 1'b0; immadiateInst = 24'h0; regjmpEnable = 1'b0; jmpTarget = 32'h0;
        exp_bc = 0;

        // Reset state
        tick(); tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_state", dbg_state, 0);
`ifdef IFU_BRANCH_COUNT_EN
        chk("rst_bc", branch_count, 0);
`endif

        // Basic streaming, every request acked with the same word
        rst = 1'b0;
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", instr_valid, 0);
        imem_ack = 1'b1; imem_rdata = 32'hD3716AFF;
        tick();
        chk("s1_instr", instruction, 32'hD3716AFF);
        chk("s1_ipc", instr_pc, 32'h0);
        chk("s1_valid", instr_valid, 1);
        chk("s1_addr", imem_addr, 32'h4);
        tick();
        chk("s2_ipc", instr_pc, 32'h4);
        chk("s2_addr", imem_addr, 32'h8);

        // Skid buffer fill and drain
        imem_ack = 1'b0; stall = 1'b1;
        tick();
        chk("stall_ipc", instr_pc, 32'h4);
        chk("stall_valid", instr_valid, 1);
        imem_ack = 1'b1; imem_rdata = 32'h17710AEF;
        tick();
        chk("skid_state", dbg_state, 2);
        chk("skid_req", imem_req, 0);
        chk("skid_instr", instruction, 32'hD3716AFF);
        imem_ack = 1'b0;
        tick();
        chk("hold_state", dbg_state, 2);
        chk("hold_req", imem_req, 0);
        stall = 1'b0;
        tick();
        chk("drain_instr", instruction, 32'h17710AEF);
        chk("drain_ipc", instr_pc, 32'h8);
        chk("drain_valid", instr_valid, 1);
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 32'hC);

        // Immediate branches from instr_pc 0x10
        imem_ack = 1'b1; imem_rdata = 32'h0000000C;
        tick(); tick();
        chk("b_ipc", instr_pc, 32'h10);
        jmpEnable = 1'b1; immadiateInst = 24'h000002;
        tick(); exp_bc++;
        chk("imm_fwd_addr", imem_addr, 32'h20);
        chk("imm_fwd_valid", instr_valid, 0);
        jmpEnable = 1'b0;
        tick();
        jmpEnable = 1'b1; immadiateInst = 24'hFFFFFA;
        tick(); exp_bc++;
        chk("imm_back_addr", imem_addr, 32'h10);
        jmpEnable = 1'b0;
        tick();
        chk("b2_ipc", instr_pc, 32'h10);
        jmpEnable = 1'b1; immadiateInst = 24'hFFFFFE;
        tick(); exp_bc++;
        chk("imm_self_addr", imem_addr, 32'h10);
        chk("imm_self_valid", instr_valid, 0);

        // Register branch has priority over immediate branch
        jmpEnable = 1'b0;
        tick();
        regjmpEnable = 1'b1; jmpEnable = 1'b1; immadiateInst = 24'h000002; jmpTarget = 32'h00000103;
        tick(); exp_bc++;
        chk("reg_prio_addr", imem_addr, 32'h100);
`ifdef IFU_BRANCH_COUNT_EN
        chk("reg_bc", branch_count, 32'(exp_bc));
`endif

        // Redirect while the read of 0x8 is outstanding
        regjmpEnable = 1'b0; jmpEnable = 1'b0;
        tick();
        regjmpEnable = 1'b1; jmpTarget = 32'h4;
        tick(); exp_bc++;
        regjmpEnable = 1'b0;
        tick();
        chk("pre_ipc", instr_pc, 32'h4);
        chk("pre_addr", imem_addr, 32'h8);
        imem_ack = 1'b0; regjmpEnable = 1'b1; jmpTarget = 32'h40;
        tick(); exp_bc++;
        regjmpEnable = 1'b0;
        chk("out_valid", instr_valid, 0);
        chk("out_req0", imem_req, 1);
        chk("out_addr0", imem_addr, 32'h8);
        tick();
        chk("out_addr1", imem_addr, 32'h8);
        tick();
        chk("out_addr2", imem_addr, 32'h8);
        imem_ack = 1'b1; imem_rdata = 32'hDB716AE3;
        tick();
        chk("drop_valid", instr_valid, 0);
        chk("drop_ipc", instr_pc, 32'h4);
        chk("drop_addr", imem_addr, 32'h40);
        chk("drop_req", imem_req, 1);
`ifdef IFU_BRANCH_COUNT_EN
        chk("drop_bc", branch_count, 32'(exp_bc));
`endif

        // Reset during an outstanding request, with a late ack
        tick();
        imem_ack = 1'b0;
        tick();
        chk("mid_req", imem_req, 1);
        rst = 1'b1;
        tick();
        chk("mr_req", imem_req, 0);
        chk("mr_valid", instr_valid, 0);
        chk("mr_addr", imem_addr, 32'h0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDB716AE3;
        tick();
        chk("late_valid", instr_valid, 0);
        chk("late_instr", instruction, 32'h0);
        chk("late_req", imem_req, 1);
        chk("late_addr", imem_addr, 32'h0);

        // PC wrap at the top of the address space
        tick();
        regjmpEnable = 1'b1; jmpTarget = 32'hFFFFFFF8;
        tick();
        regjmpEnable = 1'b0;
        chk("wrap_tgt", imem_addr, 32'hFFFFFFF8);
        tick(); tick();
        chk("wrap_ipc", instr_pc, 32'hFFFFFFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Randomized traffic against a program-order model
        rst = 1'b1; imem_ack = 1'b0;
        tick();
        rst = 1'b0;
        exp_pc = 32'h0; exp_bc = 0; n_consumed = 0;
        prev_pending = 1'b0; prev_addr = 32'h0;
        wait_cnt = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_pending) begin
                chk("rnd_req_held", imem_req, 1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            stall         = ($urandom_range(0, 3) == 0);
            regjmpEnable  = ($urandom_range(0, 9) == 0);
            jmpEnable     = ($urandom_range(0, 7) == 0);
            immadiateInst = 24'($urandom_range(0, 31)) - 24'd16;
            jmpTarget     = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 31)))
                                                         : 32'($urandom_range(0, 1023));
            if (imem_req && wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = $urandom_range(0, 3);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                if (imem_req && wait_cnt > 0) wait_cnt--;
            end
            if (instr_valid && !stall) begin
                chk("rnd_ipc", instr_pc, exp_pc);
                chk("rnd_instr", instruction, mem_word(exp_pc));
                n_consumed++;
                if (regjmpEnable) begin
                    exp_pc = jmpTarget & 32'hFFFFFFFC;
                    exp_bc++;
                end else if (jmpEnable) begin
                    off = $signed(immadiateInst);
                    exp_pc = exp_pc + 32'd8 + 32'(off * 4);
                    exp_bc++;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            tick();
        end
        chk("rnd_progress", 32'(n_consumed > 500), 1);
`ifdef IFU_BRANCH_COUNT_EN
        chk("rnd_bc", branch_count, 32'(exp_bc));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have ports:
  clk  input  1  system clock, all state updates on rising edge.
  rst  input  1  reset, synchronous, active-high.
  imem_req  output  1  instruction memory read request.
  imem_addr  output  32  word-aligned read address.
  imem_ack  input  1  memory returns data this cycle.
  imem_rdata  input  32  read data, valid when imem_ack=1.
  stall  input  1  decoder not consuming the current instruction.
  jmpEnable  input  1  decoder: immediate branch taken.
  immadiateInst  input  24  decoder: signed word offset for branch.
  regjmpEnable  input  1  decoder: register branch taken.
  jmpTarget  input  32  decoder: register branch target.
  instruction  output  32  fetched instruction to decoder.
  instr_valid  output  1  instruction holds a valid word.
  instr_pc  output  32  address of instruction.
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, HOLD; IDLE lasts exactly one cycle after reset, then FETCH.
REQ-005 In FETCH SHALL drive imem_req=1 with imem_addr=pc, both stable until the cycle imem_ack=1; in IDLE/HOLD imem_req=0.
REQ-006 Output is "consumed" in a cycle where instr_valid=1 and stall=0.
REQ-007 On imem_ack with output empty or consumed: instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, stay FETCH (next request issued the following cycle).
REQ-008 On imem_ack with instr_valid=1 and stall=1: data and address SHALL go to a one-entry skid buffer, pc<=pc+4, FSM to HOLD.
REQ-009 In HOLD, first cycle with stall=0: output<=skid contents, skid empties, FSM to FETCH.
REQ-010 If output consumed with no new data and empty skid, instr_valid<=0.
REQ-011 Redirect SHALL be sampled only when output consumed; regjmpEnable has priority over jmpEnable.
REQ-012 Immediate target = instr_pc + 8 + (sign-extend(immadiateInst) << 2), modulo 2^32; register target = jmpTarget with bits[1:0] forced to 0.
REQ-013 On redirect: pc<=target, instr_valid<=0, skid emptied, FSM to FETCH; ack in the same cycle SHALL be discarded.
REQ-014 Redirect during outstanding request (req high, no ack): request SHALL complete unchanged; returned data discarded; next request uses target.
REQ-015 PC wrap 0xFFFFFFFC+4 SHALL yield 0x00000000 without error.

Reset
REQ-016 On rst: pc=RESET_VECTOR, FSM=IDLE, imem_req=0, imem_addr=RESET_VECTOR, instruction=0, instr_pc=0, instr_valid=0, skid empty, discard flag clear.
REQ-017 rst mid-request SHALL abandon it; a late imem_ack after reset SHALL be ignored while in IDLE.

Configuration
REQ-018 Macro IFU_BRANCH_COUNT_EN defined: SHALL add output branch_count (16 bits), reset 0, +1 per accepted redirect, saturating at 0xFFFF.
REQ-019 Macro undefined: branch_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-020 Reset, ack every request with 0xD3716AFF, stall=0 -> first imem_addr 0x0 on cycle 2, instruction=0xD3716AFF instr_pc=0x0 valid, then addresses 0x4, 0x8 successive.
REQ-021 instr_valid=1, stall=1, ack 0x17710AEF -> skid fill, HOLD, imem_req=0; stall=0 -> instruction=0x17710AEF, FETCH resumes at next pc.
REQ-022 instr_pc=0x10, jmpEnable=1, immadiateInst=0x000002 -> next imem_addr 0x20; immadiateInst=0xFFFFFE -> 0x10.
REQ-023 regjmpEnable=1 and jmpEnable=1, jmpTarget=0x00000103 -> next imem_addr 0x100; branch_count increments by 1 when IFU_BRANCH_COUNT_EN.
REQ-024 Redirect while request to 0x8 outstanding, ack 3 cycles later with 0xDB716AE3 -> data dropped, instr_valid=0, next request at target.
REQ-025 rst asserted during outstanding request -> next cycle imem_req=0, instr_valid=0, fetch restarts at RESET_VECTOR.
